// File: rtl/hbus_pkg.sv
// Shared types and widths for the hbus arbiter and its round-robin picker.
package hbus_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    typedef logic [ADDR_W-1:0] hbus_addr_t;
    typedef logic [DATA_W-1:0] hbus_data_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } hbus_arb_state_e;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hbus_rr_pick.sv
// Combinational round-robin picker: the first set request at or after
// index (i_last+1), wrapping around to index 0.
module hbus_rr_pick
    import hbus_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int IDX_W = idx_width(NREQ)
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [NREQ-1:0]  o_winner,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    logic [NREQ-1:0] w_mask;
    logic [NREQ-1:0] w_hi;
    logic [NREQ-1:0] w_src;

    // Prefer requests above the last winner; otherwise wrap to the lowest set bit.
    always_comb begin
        w_mask   = '0;
        o_idx    = '0;
        o_winner = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_mask[i] = (i > int'(i_last));
        end
        w_hi  = i_req & w_mask;
        w_src = (|w_hi) ? w_hi : i_req;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_src[i]) begin
                o_idx = IDX_W'(i);
            end
        end
        o_winner[o_idx] = |i_req;
    end

    assign o_valid = |i_req;

endmodule

// File: rtl/hbus_arbiter.sv
// Round-robin arbiter sharing one hbus memory port among NREQ requesters.
// Each grant runs a fixed MEM_LAT-cycle access, then a one-cycle done pulse.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no grant; pick a winner and latch its request
//   ACCESS | mem_en high, counter runs down from MEM_LAT-1 to 0
//   DONE   | done pulse for the winner, grant still held, update last
module hbus_arbiter
    import hbus_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int MEM_LAT = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req,
    input  logic [NREQ-1:0]              we,
    input  logic [NREQ-1:0][ADDR_W-1:0]  addr,
    input  logic [NREQ-1:0][DATA_W-1:0]  wdata,
    output logic [NREQ-1:0]              gnt,
    output logic [NREQ-1:0]              done,
    output logic [DATA_W-1:0]            rdata,
    output logic                         mem_en,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            mem_rdata
);

    localparam int               IDX_W    = idx_width(NREQ);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    hbus_arb_state_e  r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [NREQ-1:0]  r_gnt, w_gnt_nxt;
    logic [NREQ-1:0]  r_done, w_done_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic [IDX_W-1:0] r_last, w_last_nxt;
    hbus_data_t       r_rdata, w_rdata_nxt;
    logic             r_we;
    hbus_addr_t       r_addr;
    hbus_data_t       r_wdata;
    logic             w_latch;
    logic             w_access;

    logic [NREQ-1:0]  w_pick_oh;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_vld;

    hbus_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req    (req),
        .i_last   (r_last),
        .o_winner (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_vld)
    );

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-value decode for grant, counter, done and read data.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gnt_nxt   = r_gnt;
        w_done_nxt  = '0;
        w_idx_nxt   = r_idx;
        w_last_nxt  = r_last;
        w_rdata_nxt = r_rdata;
        w_latch     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_pick_vld) begin
                    w_gnt_nxt   = w_pick_oh;
                    w_idx_nxt   = w_pick_idx;
                    w_latch     = 1'b1;
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (r_cnt == '0) begin
                    if (!r_we) begin
                        w_rdata_nxt = mem_rdata;
                    end
                    w_done_nxt  = r_gnt;
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            DONE: begin
                w_last_nxt  = r_idx;
                w_gnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Control and datapath registers; requester inputs are only sampled on a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_idx   <= '0;
            r_last  <= IDX_W'(NREQ - 1);
            r_rdata <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
            r_done  <= w_done_nxt;
            r_idx   <= w_idx_nxt;
            r_last  <= w_last_nxt;
            r_rdata <= w_rdata_nxt;
            if (w_latch) begin
                r_we    <= we[w_pick_idx];
                r_addr  <= addr[w_pick_idx];
                r_wdata <= wdata[w_pick_idx];
            end
        end
    end

    // Memory strobes follow the state; write enable is gated so it never
    // lingers outside an access.
    assign w_access  = (r_state == ACCESS);
    assign mem_en    = w_access;
    assign mem_we    = w_access & r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign gnt   = r_gnt;
    assign done  = r_done;
    assign rdata = r_rdata;

endmodule

// File: tb/tb_hbus_arbiter.sv
module tb_hbus_arbiter;

    localparam int NA = 2;
    localparam int LA = 2;
    localparam int NB = 4;
    localparam int LB = 1;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [NA-1:0]       req, we, gnt, done;
    logic [NA-1:0][7:0]  addr, wdata;
    logic [7:0]          rdata, mem_addr, mem_wdata, mem_rdata;
    logic                mem_en, mem_we;

    logic [NB-1:0]       b_req, b_we, b_gnt, b_done;
    logic [NB-1:0][7:0]  b_addr, b_wdata;
    logic [7:0]          b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic                b_mem_en, b_mem_we;

    function automatic logic [7:0] mem_a(input logic [7:0] a);
        return (a == 8'h10) ? 8'hA5 : (a ^ 8'h5A);
    endfunction

    assign mem_rdata   = mem_a(mem_addr);
    assign b_mem_rdata = b_mem_addr ^ 8'hC3;

    hbus_arbiter #(.NREQ(NA), .MEM_LAT(LA)) dut_a (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .done(done), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    hbus_arbiter #(.NREQ(NB), .MEM_LAT(LB)) dut_b (
        .clk(clk), .rst(rst), .req(b_req), .we(b_we), .addr(b_addr), .wdata(b_wdata),
        .gnt(b_gnt), .done(b_done), .rdata(b_rdata), .mem_en(b_mem_en), .mem_we(b_mem_we),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int         idx;
        logic [7:0] rd;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] rd_model;

    task automatic push_exp(input int idx, input logic [7:0] rd);
        exp_t x;
        x.idx = idx;
        x.rd  = rd;
        sb.push_back(x);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req = '0; we = '0; addr = '0; wdata = '0;
        b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0;
        repeat (3) @(negedge clk);
        n_vec++; if (gnt !== 2'b00)     begin n_err++; $display("FAIL reset_gnt got %b want 00", gnt); end
        n_vec++; if (done !== 2'b00)    begin n_err++; $display("FAIL reset_done got %b want 00", done); end
        n_vec++; if (rdata !== 8'h00)   begin n_err++; $display("FAIL reset_rdata got %h want 00", rdata); end
        n_vec++; if (mem_en !== 1'b0)   begin n_err++; $display("FAIL reset_mem_en got %b want 0", mem_en); end
        n_vec++; if (mem_we !== 1'b0)   begin n_err++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
        n_vec++; if (mem_addr !== 8'h00)  begin n_err++; $display("FAIL reset_mem_addr got %h want 00", mem_addr); end
        n_vec++; if (mem_wdata !== 8'h00) begin n_err++; $display("FAIL reset_mem_wdata got %h want 00", mem_wdata); end
        n_vec++; if (b_gnt !== 4'b0000) begin n_err++; $display("FAIL reset_b_gnt got %b want 0000", b_gnt); end
        rd_model = 8'h00;
        sb.delete();
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (gnt !== 2'b00) begin n_err++; $display("FAIL idle_gnt got %b want 00", gnt); end
    endtask

    task automatic test_single_read;
        exp_t e;
        req = 2'b01; we = 2'b00; addr[0] = 8'h10;
        push_exp(0, mem_a(8'h10));
        @(negedge clk);
        n_vec++; if (gnt !== 2'b01)     begin n_err++; $display("FAIL rd_gnt got %b want 01", gnt); end
        n_vec++; if (mem_en !== 1'b1)   begin n_err++; $display("FAIL rd_en1 got %b want 1", mem_en); end
        n_vec++; if (mem_addr !== 8'h10) begin n_err++; $display("FAIL rd_addr1 got %h want 10", mem_addr); end
        n_vec++; if (mem_we !== 1'b0)   begin n_err++; $display("FAIL rd_we got %b want 0", mem_we); end
        @(negedge clk);
        n_vec++; if (mem_en !== 1'b1)   begin n_err++; $display("FAIL rd_en2 got %b want 1", mem_en); end
        n_vec++; if (done !== 2'b00)    begin n_err++; $display("FAIL rd_early_done got %b want 00", done); end
        @(negedge clk);
        e = sb.pop_front();
        rd_model = e.rd;
        n_vec++; if (mem_en !== 1'b0)   begin n_err++; $display("FAIL rd_en3 got %b want 0", mem_en); end
        n_vec++; if (done !== 2'b01)    begin n_err++; $display("FAIL rd_done got %b want 01", done); end
        n_vec++; if (gnt !== 2'b01)     begin n_err++; $display("FAIL rd_gnt_done got %b want 01", gnt); end
        n_vec++; if (rdata !== rd_model) begin n_err++; $display("FAIL rd_data got %h want %h", rdata, rd_model); end
        req = 2'b00;
        @(negedge clk);
        n_vec++; if (gnt !== 2'b00 || done !== 2'b00) begin n_err++; $display("FAIL rd_release gnt %b done %b want 00 00", gnt, done); end
    endtask

    task automatic test_single_write;
        exp_t e;
        req = 2'b10; we = 2'b10; addr[1] = 8'h20; wdata[1] = 8'h3C;
        push_exp(1, rd_model);
        @(negedge clk);
        n_vec++; if (gnt !== 2'b10)      begin n_err++; $display("FAIL wr_gnt got %b want 10", gnt); end
        n_vec++; if (mem_we !== 1'b1)    begin n_err++; $display("FAIL wr_we1 got %b want 1", mem_we); end
        n_vec++; if (mem_addr !== 8'h20) begin n_err++; $display("FAIL wr_addr1 got %h want 20", mem_addr); end
        n_vec++; if (mem_wdata !== 8'h3C) begin n_err++; $display("FAIL wr_wdata1 got %h want 3c", mem_wdata); end
        addr[1] = 8'hEE; wdata[1] = 8'h11;
        @(negedge clk);
        n_vec++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin n_err++; $display("FAIL wr_en2 en %b we %b want 1 1", mem_en, mem_we); end
        n_vec++; if (mem_addr !== 8'h20) begin n_err++; $display("FAIL wr_addr_hold got %h want 20", mem_addr); end
        n_vec++; if (mem_wdata !== 8'h3C) begin n_err++; $display("FAIL wr_wdata_hold got %h want 3c", mem_wdata); end
        @(negedge clk);
        e = sb.pop_front();
        n_vec++; if (done !== 2'b10)     begin n_err++; $display("FAIL wr_done got %b want 10", done); end
        n_vec++; if (rdata !== e.rd)     begin n_err++; $display("FAIL wr_rdata_kept got %h want %h", rdata, e.rd); end
        req = 2'b00; we = 2'b00;
        @(negedge clk);
        n_vec++; if (mem_we !== 1'b0 || gnt !== 2'b00) begin n_err++; $display("FAIL wr_release we %b gnt %b want 0 00", mem_we, gnt); end
    endtask

    task automatic test_contention;
        exp_t            e;
        logic [NA-1:0]   exp_oh;
        logic [NA-1:0]   prev;
        int              starts[$];
        int              ndone;
        int              glitches;
        rst = 1'b1;
        req = 2'b11; we = 2'b00; addr[0] = 8'h30; addr[1] = 8'h31;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd_model = 8'h00;
        push_exp(0, mem_a(8'h30)); push_exp(1, mem_a(8'h31));
        push_exp(0, mem_a(8'h30)); push_exp(1, mem_a(8'h31));
        prev = '0; ndone = 0; glitches = 0;
        for (int c = 0; c < 60 && ndone < 4; c++) begin
            @(negedge clk);
            if (gnt != '0 && prev == '0) starts.push_back(c);
            if (gnt != '0 && prev != '0 && gnt != prev) glitches++;
            if (done != '0) begin
                e = sb.pop_front();
                exp_oh = '0; exp_oh[e.idx] = 1'b1;
                n_vec++; if (done !== exp_oh) begin n_err++; $display("FAIL cont_order got %b want %b", done, exp_oh); end
                n_vec++; if (rdata !== e.rd)  begin n_err++; $display("FAIL cont_rdata got %h want %h", rdata, e.rd); end
                rd_model = e.rd;
                ndone++;
                if (ndone == 4) req = 2'b00;
            end
            prev = gnt;
        end
        n_vec++; if (ndone != 4)    begin n_err++; $display("FAIL cont_timeout got %0d dones want 4", ndone); end
        n_vec++; if (glitches != 0) begin n_err++; $display("FAIL cont_gnt_change got %0d want 0", glitches); end
        n_vec++; if (starts.size() != 4) begin n_err++; $display("FAIL cont_nstarts got %0d want 4", starts.size()); end
        for (int i = 1; i < starts.size(); i++) begin
            n_vec++;
            if (starts[i] - starts[i-1] != LA + 2) begin
                n_err++; $display("FAIL cont_spacing got %0d want %0d", starts[i] - starts[i-1], LA + 2);
            end
        end
        sb.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_late_request;
        exp_t e;
        req = 2'b01; we = 2'b00; addr[0] = 8'h40; addr[1] = 8'h44;
        push_exp(0, mem_a(8'h40));
        @(negedge clk);
        n_vec++; if (gnt !== 2'b01) begin n_err++; $display("FAIL late_gnt0 got %b want 01", gnt); end
        req = 2'b11;
        push_exp(1, mem_a(8'h44));
        @(negedge clk);
        n_vec++; if (gnt !== 2'b01)      begin n_err++; $display("FAIL late_hold got %b want 01", gnt); end
        n_vec++; if (mem_addr !== 8'h40) begin n_err++; $display("FAIL late_addr0 got %h want 40", mem_addr); end
        @(negedge clk);
        e = sb.pop_front();
        n_vec++; if (done !== 2'b01)  begin n_err++; $display("FAIL late_done0 got %b want 01", done); end
        n_vec++; if (rdata !== e.rd)  begin n_err++; $display("FAIL late_rdata0 got %h want %h", rdata, e.rd); end
        req = 2'b10;
        @(negedge clk);
        n_vec++; if (gnt !== 2'b00) begin n_err++; $display("FAIL late_idle got %b want 00", gnt); end
        @(negedge clk);
        n_vec++; if (gnt !== 2'b10)      begin n_err++; $display("FAIL late_gnt1 got %b want 10", gnt); end
        n_vec++; if (mem_addr !== 8'h44) begin n_err++; $display("FAIL late_addr1 got %h want 44", mem_addr); end
        repeat (2) @(negedge clk);
        e = sb.pop_front();
        rd_model = e.rd;
        n_vec++; if (done !== 2'b10)  begin n_err++; $display("FAIL late_done1 got %b want 10", done); end
        n_vec++; if (rdata !== e.rd)  begin n_err++; $display("FAIL late_rdata1 got %h want %h", rdata, e.rd); end
        req = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access;
        exp_t e;
        req = 2'b01; we = 2'b00; addr[0] = 8'h50; addr[1] = 8'h51;
        push_exp(0, mem_a(8'h50));
        repeat (3) @(negedge clk);
        e = sb.pop_front();
        n_vec++; if (done !== 2'b01) begin n_err++; $display("FAIL rmid_pre_done got %b want 01", done); end
        req = 2'b10;
        repeat (2) @(negedge clk);
        n_vec++; if (gnt !== 2'b10 || mem_en !== 1'b1) begin n_err++; $display("FAIL rmid_gnt1 gnt %b en %b want 10 1", gnt, mem_en); end
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (gnt !== 2'b00)     begin n_err++; $display("FAIL rmid_gnt got %b want 00", gnt); end
        n_vec++; if (mem_en !== 1'b0)   begin n_err++; $display("FAIL rmid_mem_en got %b want 0", mem_en); end
        n_vec++; if (done !== 2'b00)    begin n_err++; $display("FAIL rmid_done got %b want 00", done); end
        n_vec++; if (mem_addr !== 8'h00) begin n_err++; $display("FAIL rmid_mem_addr got %h want 00", mem_addr); end
        rd_model = 8'h00;
        rst = 1'b0;
        req = 2'b11; addr[0] = 8'h52;
        push_exp(0, mem_a(8'h52));
        @(negedge clk);
        n_vec++; if (gnt !== 2'b01)  begin n_err++; $display("FAIL rmid_prio got %b want 01", gnt); end
        n_vec++; if (done !== 2'b00) begin n_err++; $display("FAIL rmid_no_done got %b want 00", done); end
        repeat (2) @(negedge clk);
        e = sb.pop_front();
        rd_model = e.rd;
        n_vec++; if (done !== 2'b01) begin n_err++; $display("FAIL rmid_post_done got %b want 01", done); end
        n_vec++; if (rdata !== e.rd) begin n_err++; $display("FAIL rmid_rdata got %h want %h", rdata, e.rd); end
        req = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_lat1_nreq4;
        exp_t            e;
        logic [NB-1:0]   exp_oh;
        logic [NB-1:0]   prev;
        int              starts[$];
        int              ndone;
        int              en_cnt;
        b_req = 4'b1010; b_we = '0; b_addr[1] = 8'h11; b_addr[3] = 8'h33;
        push_exp(1, 8'h11 ^ 8'hC3);
        push_exp(3, 8'h33 ^ 8'hC3);
        prev = '0; ndone = 0; en_cnt = 0;
        for (int c = 0; c < 30 && ndone < 2; c++) begin
            @(negedge clk);
            if (b_gnt != '0 && prev == '0) starts.push_back(c);
            if (b_mem_en) en_cnt++;
            if (b_done != '0) begin
                e = sb.pop_front();
                exp_oh = '0; exp_oh[e.idx] = 1'b1;
                n_vec++; if (b_done !== exp_oh) begin n_err++; $display("FAIL lat1_order got %b want %b", b_done, exp_oh); end
                n_vec++; if (b_rdata !== e.rd)  begin n_err++; $display("FAIL lat1_rdata got %h want %h", b_rdata, e.rd); end
                n_vec++; if (en_cnt != LB)      begin n_err++; $display("FAIL lat1_en_cycles got %0d want %0d", en_cnt, LB); end
                en_cnt = 0;
                ndone++;
                if (ndone == 2) b_req = '0;
            end
            prev = b_gnt;
        end
        n_vec++; if (ndone != 2) begin n_err++; $display("FAIL lat1_timeout got %0d dones want 2", ndone); end
        n_vec++; if (starts.size() != 2) begin n_err++; $display("FAIL lat1_nstarts got %0d want 2", starts.size()); end
        for (int i = 1; i < starts.size(); i++) begin
            n_vec++;
            if (starts[i] - starts[i-1] != LB + 2) begin
                n_err++; $display("FAIL lat1_spacing got %0d want %0d", starts[i] - starts[i-1], LB + 2);
            end
        end
        sb.delete();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_late_request();
        test_reset_mid_access();
        test_lat1_nreq4();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hbus_arbiter.md
# hbus_arbiter

Round-robin arbiter and transaction sequencer that shares a single hbus memory port among NREQ CPU requesters. Each requester issues a single-beat read or write with an 8-bit address and 8-bit data. The block grants one requester at a time, drives the memory port for a fixed access latency, and returns read data with a one-cycle completion pulse. It sits between multiple `cpu_hbus`-class masters and one `mem_hbus`-class memory on the same `clk`.

## Interface
- NREQ, 2 — number of requesters, 2..8
- MEM_LAT, 2 — memory access cycles per transaction, 1..15
- clk  in  1  — bus clock, rising edge
- rst  in  1  — synchronous, active-high reset
- req  in  NREQ  — per-requester transaction request; level, held until done
- we  in  NREQ  — per-requester write enable (1 = write, 0 = read); valid while req is high
- addr  in  NREQ x 8  — per-requester address
- wdata  in  NREQ x 8  — per-requester write data
- gnt  out  NREQ  — one-hot grant, high for the whole transaction
- done  out  NREQ  — one-hot, one-cycle completion pulse
- rdata  out  8  — read data for the completed read; valid in the done cycle
- mem_en  out  1  — memory access strobe
- mem_we  out  1  — memory write enable
- mem_addr  out  8  — memory address
- mem_wdata  out  8  — memory write data
- mem_rdata  in  8  — memory read data; valid in the last mem_en cycle

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE**
  - If any req bit is high, select a winner by round robin. The search starts at index (last+1) mod NREQ and takes the first set bit.
  - Register gnt to the winner. Latch the winner's we, addr and wdata.
  - Load the counter with MEM_LAT-1 and go to ACCESS.
  - If no req bit is high, stay in IDLE.
- **ACCESS**
  - mem_en = 1. mem_we, mem_addr and mem_wdata come from the latched values and are stable for the whole state.
  - Decrement the counter each cycle.
  - When the counter is 0: capture mem_rdata into rdata if this is a read, then go to DONE.
- **DONE**
  - done[winner] = 1 and gnt is still held. Set last = winner, then go to IDLE and clear gnt.
- Requester inputs are ignored after latching. If a requester changes addr or wdata during a grant, the transaction in flight is unaffected.
- A requester that keeps req high after done re-enters arbitration at lowest priority relative to its own last grant.
- rdata holds its value until the next completed read. A write does not change rdata.
- Reset values: state = IDLE, gnt = 0, done = 0, rdata = 0, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- After reset, last = NREQ-1, so requester 0 has first priority.
- Reset during ACCESS or DONE aborts the transaction: no done pulse is issued and memory outputs clear on the next edge.

## Timing
- req sampled high in IDLE at edge T gives:
  - gnt and mem_en from T+1
  - mem_en for exactly MEM_LAT cycles (T+1 .. T+MEM_LAT)
  - done and rdata at T+MEM_LAT+1
  - IDLE at T+MEM_LAT+2
- Minimum spacing between grants is MEM_LAT+2 cycles.
- gnt and done are registered outputs. No output depends combinationally on req.
- Requests arriving during ACCESS or DONE wait for IDLE. Simultaneous requests are resolved in the same IDLE cycle by the round-robin rule only.
- The counter is 4 bits. MEM_LAT=1 gives a single ACCESS cycle.

## Structure
- Package `hbus_pkg` holds:
  - ADDR_W = 8 and DATA_W = 8
  - the state enum typedef `hbus_arb_state_e` {IDLE, ACCESS, DONE}
  - the typedef `hbus_addr_t` / `hbus_data_t`
- Sub-module `hbus_rr_pick`: a combinational round-robin picker. Inputs are req[NREQ] and last index; output is a one-hot winner plus its index. It is instantiated once in the IDLE decision path.
- All state, counter and datapath registers live in `hbus_arbiter`.

## Test plan
- **Single read:** NREQ=2, MEM_LAT=2. Requester 0 reads addr 8'h10 while the memory model returns 8'hA5.
  - gnt=2'b01 at T+1; mem_en high for 2 cycles with mem_addr=8'h10.
  - done=2'b01 and rdata=8'hA5 at T+3.
- **Single write:** requester 1 writes 8'h3C to 8'h20.
  - mem_we=1, mem_addr=8'h20, mem_wdata=8'h3C for MEM_LAT cycles.
  - done=2'b10; rdata unchanged.
- **Contention:** req=2'b11 held continuously from reset.
  - Grant order is 0,1,0,1.
  - Each grant starts exactly MEM_LAT+2 cycles after the previous one.
- **Late request:** requester 1 raises req during requester 0's ACCESS.
  - No gnt change mid-transaction; requester 1 is granted in the next IDLE.
- **Reset mid-ACCESS:** assert rst in the first ACCESS cycle.
  - Next edge: gnt=0, mem_en=0, state IDLE.
  - No done pulse; after release, requester 0 wins first.
- **MEM_LAT=1, NREQ=4:** req=4'b1010.
  - Grants go to 1 then 3, each with exactly one mem_en cycle.
